// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
package data_memory_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_DATA_W = 8;

  // Memory-mapped I/O addresses, decoded by the manager, not here
  localparam logic [MEM_ADDR_W-1:0] INPUT_PORT  = 10'h3FE;
  localparam logic [MEM_ADDR_W-1:0] OUTPUT_PORT = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// Two-way request picker with a registered last-winner pointer.
module rr_arbiter_2 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] pick
);

  // 1 = requester 1 was served last, so requester 0 wins the next tie
  logic last;

  // Last-winner pointer, moved only when a grant is actually issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (update) begin
      last <= pick[1];
    end
  end

  // Combinational pick: lone requester always wins, ties resolved by mode
  always_comb begin
    pick = '0;
    if (FIXED_PRIORITY) begin
      if (req[0])      pick = 2'b01;
      else if (req[1]) pick = 2'b10;
    end else begin
      unique case (req)
        2'b01:   pick = 2'b01;
        2'b10:   pick = 2'b10;
        2'b11:   pick = last ? 2'b01 : 2'b10;
        default: pick = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the data_memory_manager between the CPU (req0) and DMA (req1).
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = MEM_ADDR_W,
  parameter int unsigned DATA_W         = MEM_DATA_W,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_req,
  input  logic [1:0]        in_we,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_wdata0,
  input  logic [DATA_W-1:0] in_wdata1,
  output logic [1:0]        out_gnt,
  output logic [1:0]        out_rvalid,
  output logic [DATA_W-1:0] out_rdata,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_mem_addr_we,
  output logic              out_mem_read_en,
  output logic              out_mem_write_en,
  input  logic [DATA_W-1:0] in_mem_data
);

  state_t            state, state_next;
  logic [1:0]        pick;
  logic              grant;
  logic              sel;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        sel_onehot;

  // Grant opportunities exist only in IDLE and RESP (the RESP one gives back-to-back)
  always_comb begin
    grant      = ((state == IDLE) || (state == RESP)) && (|in_req);
    sel_onehot = sel ? 2'b10 : 2'b01;
  end

  rr_arbiter_2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (in_req),
    .update(grant),
    .pick  (pick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: fixed three-cycle sequence per access
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = grant ? ADDR : IDLE;
      ADDR:    state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = grant ? ADDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's operands at the grant edge; addr_q doubles as the held bus address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      sel     <= pick[1];
      we_q    <= pick[1] ? in_we[1]   : in_we[0];
      addr_q  <= pick[1] ? in_addr1   : in_addr0;
      wdata_q <= pick[1] ? in_wdata1  : in_wdata0;
    end
  end

  // Read data sampled at the end of ACCESS; writes leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if ((state == ACCESS) && !we_q) begin
      rdata_q <= in_mem_data;
    end
  end

  // Phase-decoded outputs towards requesters and manager
  always_comb begin
    out_gnt          = (state == ADDR) ? sel_onehot : 2'b00;
    out_rvalid       = (state == RESP) ? sel_onehot : 2'b00;
    out_rdata        = rdata_q;
    out_mem_addr     = addr_q;
    out_mem_addr_we  = (state == ADDR);
    out_mem_read_en  = (state == ACCESS) && !we_q;
    out_mem_write_en = (state == ACCESS) && we_q;
    out_mem_data     = ((state == ACCESS) && we_q) ? wdata_q : '0;
  end

endmodule
